// File: rtl/pri_enc_req_arbiter.sv
// Round-robin arbiter sharing one priority encoder among NUM_REQ operand requesters.
// Optional watchdog enabled by defining PRI_ENC_ARB_TIMEOUT_EN.
module pri_enc_req_arbiter #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*SIZE-1:0]   req_in1_i,
    input  logic [NUM_REQ*SIZE-1:0]   req_in2_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      enc_valid_o,
    output logic [SIZE-1:0]           enc_in1_o,
    output logic [SIZE-1:0]           enc_in2_o,
    input  logic                      enc_valid_i,
    input  logic [$clog2(SIZE)-1:0]   enc_match_addr_i,
    input  logic                      enc_last_i,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [$clog2(SIZE)-1:0]   rsp_addr_o,
    output logic                      rsp_last_o,
    output logic                      rsp_empty_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int ADDR_W = $clog2(SIZE);

    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("pri_enc_req_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        EMPTY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [SIZE-1:0]   op1_q, op2_q;
    logic [NUM_REQ-1:0] ready_q;
    logic              rsp_valid_q, rsp_last_q, rsp_empty_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [ADDR_W-1:0] rsp_addr_q;

    logic              hi_found;
    logic [ID_W-1:0]   hi_idx, lo_idx, grant_idx;
    logic [SIZE-1:0]   grant_in1, grant_in2;
    logic              grant_take, job_done, wd_expired;
    logic [ID_W-1:0]   ptr_next;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                lo_idx = ID_W'(k);
                if (ID_W'(k) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(k);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        grant_in1 = '0;
        grant_in2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == grant_idx) begin
                grant_in1 = req_in1_i[k*SIZE +: SIZE];
                grant_in2 = req_in2_i[k*SIZE +: SIZE];
            end
        end
    end

    assign ptr_next = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

`ifdef PRI_ENC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            err_q;

    // Counts consecutive RUN cycles without an encoder beat.
    assign wd_expired = (state_q == RUN) && !enc_valid_i &&
                        (wd_cnt_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q != RUN || enc_valid_i) begin
                wd_cnt_q <= '0;
            end else if (!wd_expired) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (wd_expired) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign wd_expired = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        job_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    grant_take = 1'b1;
                    state_d    = ((grant_in1 & grant_in2) == '0) ? EMPTY : RUN;
                end
            end
            RUN: begin
                if (enc_valid_i && enc_last_i) begin
                    job_done = 1'b1;
                    state_d  = IDLE;
                end else if (wd_expired) begin
                    job_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            EMPTY: begin
                job_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            id_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            ready_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_empty_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_addr_q  <= '0;
        end else begin
            ready_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_empty_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_addr_q  <= '0;

            if (grant_take) begin
                ready_q[grant_idx] <= 1'b1;
                id_q               <= grant_idx;
                op1_q              <= grant_in1;
                op2_q              <= grant_in2;
            end

            if (state_q == RUN && enc_valid_i) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_addr_q  <= enc_match_addr_i;
                rsp_last_q  <= enc_last_i;
            end

            // Empty jobs and watchdog aborts both close with a single empty/last beat.
            if (state_q == EMPTY || wd_expired) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_last_q  <= 1'b1;
                rsp_empty_q <= 1'b1;
            end

            if (job_done) begin
                ptr_q <= ptr_next;
            end
        end
    end

    assign req_ready_o = ready_q;
    assign enc_valid_o = (state_q == RUN);
    assign enc_in1_o   = op1_q;
    assign enc_in2_o   = op2_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_empty_o = rsp_empty_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_pri_enc_req_arbiter.sv
// Self-checking bench for pri_enc_req_arbiter: directed scenarios plus randomized jobs
// against a queue-based reference model; the bench also plays the encoder.
module tb_pri_enc_req_arbiter;

    localparam int SIZE    = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ*SIZE-1:0] req_in1_i, req_in2_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic                    enc_valid_o;
    logic [SIZE-1:0]         enc_in1_o, enc_in2_o;
    logic                    enc_valid_i;
    logic [2:0]              enc_match_addr_i;
    logic                    enc_last_i;
    logic                    rsp_valid_o;
    logic [ID_W-1:0]         rsp_id_o;
    logic [2:0]              rsp_addr_o;
    logic                    rsp_last_o, rsp_empty_o, busy_o, err_o;

    pri_enc_req_arbiter #(.SIZE(SIZE), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_in1_i(req_in1_i), .req_in2_i(req_in2_i),
        .req_ready_o(req_ready_o),
        .enc_valid_o(enc_valid_o), .enc_in1_o(enc_in1_o), .enc_in2_o(enc_in2_o),
        .enc_valid_i(enc_valid_i), .enc_match_addr_i(enc_match_addr_i), .enc_last_i(enc_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_addr_o(rsp_addr_o),
        .rsp_last_o(rsp_last_o), .rsp_empty_o(rsp_empty_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [NUM_REQ-1:0] pend;
    logic [SIZE-1:0]    op1 [NUM_REQ];
    logic [SIZE-1:0]    op2 [NUM_REQ];
    int                 ptr_m;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive_req();
        req_valid_i = pend;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_in1_i[k*SIZE +: SIZE] = op1[k];
            req_in2_i[k*SIZE +: SIZE] = op2[k];
        end
    endtask

    // Reference arbitration: scan from the pointer with modular arithmetic.
    function automatic int exp_grant(input logic [NUM_REQ-1:0] p, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (p[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},    req_ready_o, 0);
        check({tag, "_encv"},     enc_valid_o, 0);
        check({tag, "_in1"},      enc_in1_o,   0);
        check({tag, "_in2"},      enc_in2_o,   0);
        check({tag, "_rspv"},     rsp_valid_o, 0);
        check({tag, "_rspid"},    rsp_id_o,    0);
        check({tag, "_rspaddr"},  rsp_addr_o,  0);
        check({tag, "_rsplast"},  rsp_last_o,  0);
        check({tag, "_rspempty"}, rsp_empty_o, 0);
        check({tag, "_busy"},     busy_o,      0);
        check({tag, "_err"},      err_o,       0);
    endtask

    // One complete job starting from an IDLE cycle with requests already driven.
    task automatic run_job(input int stall_max, input bit keep);
        int          g;
        logic [SIZE-1:0] a, b, m;
        int          addrs[$];
        g = exp_grant(pend, ptr_m);
        a = op1[g];
        b = op2[g];
        m = a & b;
        for (int i = SIZE - 1; i >= 0; i--) if (m[i]) addrs.push_back(i);

        // Encoder chatter while idle must be ignored.
        enc_valid_i      = 1'($urandom_range(0, 1));
        enc_last_i       = 1'b1;
        enc_match_addr_i = 3'($urandom_range(0, 7));
        tick();
        check("grant_ready", req_ready_o, 32'(1) << g);
        check("grant_busy", busy_o, 1);
        check("issue_encv", enc_valid_o, (m != 0) ? 1 : 0);
        if (!keep) begin
            pend[g] = 1'b0;
            drive_req();
        end

        if (m == 0) begin
            enc_valid_i = 1'($urandom_range(0, 1));
            tick();
            check("empty_rspv", rsp_valid_o, 1);
            check("empty_id", rsp_id_o, g);
            check("empty_flag", rsp_empty_o, 1);
            check("empty_last", rsp_last_o, 1);
            check("empty_addr", rsp_addr_o, 0);
            check("empty_encv", enc_valid_o, 0);
            check("empty_ready", req_ready_o, 0);
        end else begin
            check("run_in1", enc_in1_o, a);
            check("run_in2", enc_in2_o, b);
            for (int k = 0; k < addrs.size(); k++) begin
                int stalls;
                stalls = $urandom_range(0, stall_max);
                for (int s = 0; s < stalls; s++) begin
                    enc_valid_i = 1'b0;
                    enc_last_i  = 1'($urandom_range(0, 1));
                    tick();
                    check("stall_rspv", rsp_valid_o, 0);
                    check("stall_encv", enc_valid_o, 1);
                    check("stall_in1", enc_in1_o, a);
                end
                enc_valid_i      = 1'b1;
                enc_match_addr_i = 3'(addrs[k]);
                enc_last_i       = (k == addrs.size() - 1);
                tick();
                check("beat_rspv", rsp_valid_o, 1);
                check("beat_id", rsp_id_o, g);
                check("beat_addr", rsp_addr_o, addrs[k]);
                check("beat_last", rsp_last_o, (k == addrs.size() - 1) ? 1 : 0);
                check("beat_empty", rsp_empty_o, 0);
            end
            enc_valid_i = 1'b0;
            enc_last_i  = 1'b0;
        end
        check("done_encv", enc_valid_o, 0);
        check("done_busy", busy_o, 0);
        ptr_m = (g + 1) % NUM_REQ;
    endtask

    initial begin
        int n;
        int g;
        rst_i            = 1'b1;
        enc_valid_i      = 1'b0;
        enc_last_i       = 1'b0;
        enc_match_addr_i = '0;
        pend             = '1;
        for (int k = 0; k < NUM_REQ; k++) begin
            op1[k] = 8'h5A + 8'(k);
            op2[k] = 8'hFF;
        end
        drive_req();

        // Reset held with every requester asserting.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check_all_zero("reset");
        end
        rst_i = 1'b0;
        ptr_m = 0;

        // Requester 0 alone: A5 & FF -> 7,5,2,0.
        pend   = 4'b0001;
        op1[0] = 8'hA5;
        op2[0] = 8'hFF;
        drive_req();
        run_job(0, 1'b0);

        // All requesters held: round-robin continues from pointer 1.
        pend = '1;
        for (int k = 0; k < NUM_REQ; k++) begin
            op1[k] = 8'($urandom);
            op2[k] = 8'($urandom) | 8'h01;
            op1[k][0] = 1'b1;
        end
        drive_req();
        for (int j = 0; j < 5; j++) run_job(1, 1'b1);

        // No requests: arbiter stays idle.
        pend = '0;
        drive_req();
        tick();
        check("idle_busy", busy_o, 0);
        check("idle_ready", req_ready_o, 0);

        // Requester 2 with disjoint operands produces a single empty beat.
        pend   = 4'b0100;
        op1[2] = 8'hF0;
        op2[2] = 8'h0F;
        drive_req();
        run_job(0, 1'b0);

        // Reset during the addr-5 beat of an A5/FF job.
        pend   = 4'b0001;
        op1[0] = 8'hA5;
        op2[0] = 8'hFF;
        drive_req();
        g = exp_grant(pend, ptr_m);
        tick();
        check("abort_ready", req_ready_o, 32'(1) << g);
        pend = '0;
        drive_req();
        enc_valid_i      = 1'b1;
        enc_match_addr_i = 3'd7;
        enc_last_i       = 1'b0;
        tick();
        check("abort_beat7", rsp_addr_o, 7);
        enc_match_addr_i = 3'd5;
        #2 rst_i = 1'b1;
        #1;
        check("abort_rspv", rsp_valid_o, 0);
        check("abort_encv", enc_valid_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_in1", enc_in1_o, 0);
        enc_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        ptr_m = 0;
        pend   = 4'b1010;
        op1[1] = 8'h3C; op2[1] = 8'h18;
        op1[3] = 8'h81; op2[3] = 8'h7E;
        drive_req();
        run_job(0, 1'b0);
        run_job(0, 1'b0);

        // Randomized traffic with protocol-respecting requesters.
        for (int j = 0; j < 40; j++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    op1[k]  = 8'($urandom);
                    op2[k]  = ($urandom_range(0, 3) == 0) ? ~op1[k] : 8'($urandom);
                end
            end
            if (pend == '0) begin
                n       = $urandom_range(0, NUM_REQ - 1);
                pend[n] = 1'b1;
                op1[n]  = 8'($urandom);
                op2[n]  = 8'($urandom);
            end
            drive_req();
            run_job(2, 1'b0);
        end

`ifdef PRI_ENC_ARB_TIMEOUT_EN
        // Encoder stalls after one beat: watchdog closes the job.
        pend   = 4'b0001;
        op1[0] = 8'hA5;
        op2[0] = 8'hFF;
        drive_req();
        g = exp_grant(pend, ptr_m);
        tick();
        check("wd_ready", req_ready_o, 32'(1) << g);
        pend = '0;
        drive_req();
        enc_valid_i      = 1'b1;
        enc_match_addr_i = 3'd7;
        enc_last_i       = 1'b0;
        tick();
        check("wd_beat7", rsp_addr_o, 7);
        enc_valid_i = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid_o && n < TIMEOUT + 8);
        check("wd_cycles", n, TIMEOUT);
        check("wd_rspv", rsp_valid_o, 1);
        check("wd_id", rsp_id_o, g);
        check("wd_empty", rsp_empty_o, 1);
        check("wd_last", rsp_last_o, 1);
        check("wd_err", err_o, 1);
        check("wd_busy", busy_o, 0);
        ptr_m = (g + 1) % NUM_REQ;
        pend   = 4'b0100;
        op1[2] = 8'h0F;
        op2[2] = 8'hF0;
        drive_req();
        run_job(0, 1'b0);
        check("wd_err_sticky", err_o, 1);
`else
        check("err_tied", err_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
